rr_arbiter4: RTL

//   4-way round-robin arbiter granting a single shared processor resource
//     (register-file write port / memory bus) to one of four requesters.

---
 rtl/arb_pkg.sv | 14 +
 rtl/decoder2to4.sv | 20 ++
 rtl/rr_pick4.sv | 38 +++
 rtl/rr_arbiter4.sv | 121 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
//------------------------------------------------------------------------------
// arb_pkg : shared sizes and state encoding for the round-robin arbiter
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

`default_nettype wire

// File: rtl/decoder2to4.sv
//------------------------------------------------------------------------------
// decoder2to4 : 2-bit index to one-hot decoder with enable
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module decoder2to4 (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    if (en) onehot = 4'b0001 << idx;
  end

endmodule

`default_nettype wire

// File: rtl/rr_pick4.sv
//------------------------------------------------------------------------------
// rr_pick4 : combinational rotating-priority picker, ptr has highest priority
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   cand;

  assign eligible = req & ~mask;

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (eligible[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter4.sv
//------------------------------------------------------------------------------
// rr_arbiter4 : 4-way round-robin arbiter, grant held until owner releases.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  arb_state_t         state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   idx_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic               forced;
  logic               release_now;
  logic               load;

  assign release_now = (state == ARB_BUSY) && (done || !req[gnt_idx] || forced);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt;

  assign forced  = (state == ARB_BUSY) && !done && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign timeout = forced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 hold_cnt <= '0;
    else if (load)              hold_cnt <= '0;
    else if (state == ARB_BUSY) hold_cnt <= hold_cnt + HOLD_W'(1);
  end
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .mask (pick_mask),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // On release the current owner is masked and priority moves just past it.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    idx_n     = gnt_idx;
    pick_ptr  = ptr;
    pick_mask = '0;
    load      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_n = ARB_BUSY;
          idx_n   = pick_idx;
          load    = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (release_now) begin
          ptr_n     = gnt_idx + IDX_W'(1);
          pick_ptr  = gnt_idx + IDX_W'(1);
          pick_mask = gnt;
          if (pick_any) begin
            idx_n = pick_idx;
            load  = 1'b1;
          end else begin
            state_n = ARB_IDLE;
            idx_n   = '0;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  decoder2to4 u_dec (
    .idx    (idx_n),
    .en     (state_n == ARB_BUSY),
    .onehot (gnt_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      gnt_idx   <= idx_n;
      gnt_valid <= (state_n == ARB_BUSY);
    end
  end

endmodule

`default_nettype wire
